pcie_loopback_checker: RTL and testbench
========================================

# pcie_loopback_checker

Parametrised self-checking traffic source and recovered-data checker for the PCIe TX / dual-synthesised RX loopback path. It generates a multi-lane counting byte stream with K-code flags and a TX-enable gap. It delays the stream through a per-lane history line and compares it with the recovered bytes. The loopback latency is found automatically. The block reports lock status, the latency, a saturating error count and per-lane sticky error flags. It sits beside the encoder/decoder pair at bench or BIST level, replacing fixed two-stage delay-and-compare logic.

## Interface
- LANES, 1, number of byte lanes
- MAX_LAT, 8, largest latency searched, in cycles (0..MAX_LAT)
- LOCK_CNT, 16, consecutive full matches needed to lock
- ERR_LIMIT, 4, consecutive mismatching compares that drop lock
- CNT_W, 16, error counter width
- PCLK250  in  1  clock, all logic on rising edge
- CNTL_RESETN_P0  in  1  asynchronous, active-low reset
- gen_en  in  1  advance the generator counter
- idle_code  in  8  lane-0 byte value at which gen_txen deasserts (nominal 8'h25)
- clr_err  in  1  clear err_cnt and lane_err
- gen_data  out  8*LANES  generated bytes, lane i in bits [8i+7:8i]
- gen_datak  out  LANES  K flag per lane
- gen_txen  out  1  TX enable for the encoder
- rx_valid  in  1  rx_data/rx_datak valid this cycle
- rx_data  in  8*LANES  recovered bytes
- rx_datak  in  LANES  recovered K flags
- locked  out  1  latency found and tracking
- lat  out  $clog2(MAX_LAT+1)  current or candidate latency
- err_cnt  out  CNT_W  saturating mismatch count while locked
- lane_err  out  LANES  sticky per-lane mismatch flags

## Operation
- Generator: 8-bit counter cnt, which increments mod 256 when gen_en=1 and holds otherwise.
  - Lane i byte = cnt+i mod 256.
  - datak = byte in {1C,3C,5C,9C,BC,DC,FC,F7,FB,FD,FE}; 7C is not a K code here.
  - gen_txen = (lane-0 byte != idle_code).
  - All three outputs are registered.
- History: each cycle, shift {gen_data, gen_datak, gen_txen} into a line of depth MAX_LAT+1. Entry k is the output from k cycles earlier; entry 0 is the current output.
- Compare occurs when rx_valid=1 and history[lat].txen=1.
  - A lane matches when its data and datak both equal history[lat].
  - A cycle with no compare leaves all counters unchanged.
- FSM states: SEARCH and LOCKED.
  - SEARCH, all lanes match: run++. When run reaches LOCK_CNT, go to LOCKED and clear run.
  - SEARCH, any mismatch: clear run; lat = (lat==MAX_LAT) ? 0 : lat+1.
  - LOCKED, all lanes match: clear consec.
  - LOCKED, any mismatch: err_cnt++ (saturating at all-ones), OR the mismatching lanes into lane_err, consec++.
  - LOCKED: when consec reaches ERR_LIMIT, go to SEARCH with lat=0 and run, consec cleared. err_cnt and lane_err are kept.
- clr_err together with a mismatch: the clear applies first, then the new event. Result: err_cnt=1, lane_err=the current mismatching lanes.
- Mismatches in SEARCH never touch err_cnt or lane_err.

## Timing
- Reset values: gen_data=0, gen_datak=0, gen_txen=0, locked=0, lat=0, err_cnt=0, lane_err=0, FSM in SEARCH, history cleared with txen=0.
  - The first clock after reset release registers cnt=0 with the correct datak/txen.
- Generator output updates one cycle after the gen_en sample.
- Checker outputs (locked, lat, err_cnt, lane_err) update on the clock edge that samples the compared rx beat; they are visible the next cycle.
- Worst-case lock time is (MAX_LAT+1)*LOCK_CNT compared cycles plus mismatch cycles.
- Latency greater than MAX_LAT: the block never locks and lat cycles 0..MAX_LAT continuously.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock.

## Structure
- Package pcie_chk_pkg holds:
  - function is_kcode(byte) with the K set above
  - FSM state enum {SEARCH, LOCKED}
  - localparam IDLE_CODE_DEF=8'h25
- Sub-module pcie_chk_lane, instantiated LANES times via generate, holds:
  - the per-lane byte generator (cnt+i)
  - the history line
  - the lat-indexed comparator, which outputs a match bit
- The top holds cnt, the FSM and the counters.

## Test plan
- LANES=1, loopback of gen_data delayed 2 cycles: locked=1 within 3*16 compares, lat=2, err_cnt stays 0 over 1000 cycles.
- K flags: gen_data 8'h1C gives datak=1; 8'h7C gives 0; 8'hF7 gives 1; 8'h25 gives gen_txen=0, and the matching rx beat is not compared even if corrupted.
- LANES=4, locked, flip one rx bit on lane 1 for one beat: err_cnt=1, lane_err=4'b0010, locked stays 1.
- Locked, corrupt 4 consecutive compared beats: locked=0 after the 4th, err_cnt=4, re-lock at lat=2 after 16 clean compares. clr_err with a simultaneous error gives err_cnt=1.
- Delay 9 with MAX_LAT=8: locked never asserts, and lat wraps 8 to 0.
- Assert CNTL_RESETN_P0 low between clock edges while locked: all outputs go to their reset values before the next edge.

Source files
------------

// File: rtl/pcie_chk_pkg.sv
// Shared types and helpers for the PCIe loopback traffic checker.
package pcie_chk_pkg;

    localparam logic [7:0] IDLE_CODE_DEF = 8'h25;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    // K-code set used by the generator; 7C is deliberately not included.
    function automatic logic is_kcode(input logic [7:0] b);
        case (b)
            8'h1C, 8'h3C, 8'h5C, 8'h9C, 8'hBC, 8'hDC,
            8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE: is_kcode = 1'b1;
            default:                           is_kcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pcie_chk_lane.sv
// One byte lane: counting-byte generator, history line and latency-indexed compare.
module pcie_chk_lane
    import pcie_chk_pkg::*;
#(
    parameter int unsigned LANE_IDX = 0,
    parameter int unsigned MAX_LAT  = 8,
    parameter int unsigned LAT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       i_cnt,
    input  logic [LAT_W-1:0] i_lat,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_datak,
    output logic [7:0]       o_gen_data,
    output logic             o_gen_datak,
    output logic             o_match_c
);

    logic [7:0] w_byte;
    logic [7:0] r_hist_data [MAX_LAT+1];
    logic       r_hist_k    [MAX_LAT+1];

    assign w_byte = i_cnt + 8'(LANE_IDX);

    // Entry 0 is the registered generator output; older entries shift down the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k <= MAX_LAT; k++) begin
                r_hist_data[k] <= '0;
                r_hist_k[k]    <= 1'b0;
            end
        end else begin
            r_hist_data[0] <= w_byte;
            r_hist_k[0]    <= is_kcode(w_byte);
            for (int unsigned k = 1; k <= MAX_LAT; k++) begin
                r_hist_data[k] <= r_hist_data[k-1];
                r_hist_k[k]    <= r_hist_k[k-1];
            end
        end
    end

    assign o_gen_data  = r_hist_data[0];
    assign o_gen_datak = r_hist_k[0];
    assign o_match_c   = (i_rx_data == r_hist_data[i_lat]) && (i_rx_datak == r_hist_k[i_lat]);

endmodule

// File: rtl/pcie_loopback_checker.sv
// Loopback traffic source and recovered-data checker with automatic latency search.
module pcie_loopback_checker
    import pcie_chk_pkg::*;
#(
    parameter int unsigned LANES     = 1,
    parameter int unsigned MAX_LAT   = 8,
    parameter int unsigned LOCK_CNT  = 16,
    parameter int unsigned ERR_LIMIT = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         PCLK250,
    input  logic                         CNTL_RESETN_P0,
    input  logic                         gen_en,
    input  logic [7:0]                   idle_code,
    input  logic                         clr_err,
    output logic [8*LANES-1:0]           gen_data,
    output logic [LANES-1:0]             gen_datak,
    output logic                         gen_txen,
    input  logic                         rx_valid,
    input  logic [8*LANES-1:0]           rx_data,
    input  logic [LANES-1:0]             rx_datak,
    output logic                         locked,
    output logic [$clog2(MAX_LAT+1)-1:0] lat,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [LANES-1:0]             lane_err
);

    localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
    localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned CON_W = $clog2(ERR_LIMIT + 1);

    logic [7:0]       r_cnt;
    logic             r_txen_hist [MAX_LAT+1];
    chk_state_e       r_state, w_state_nxt;
    logic [LAT_W-1:0] r_lat, w_lat_nxt;
    logic [RUN_W-1:0] r_run, w_run_nxt, w_run_inc;
    logic [CON_W-1:0] r_consec, w_consec_nxt, w_consec_inc;
    logic [CNT_W-1:0] r_err_cnt, w_err_nxt;
    logic [LANES-1:0] r_lane_err, w_lane_err_nxt;
    logic [LANES-1:0] w_match;
    logic             w_cmp;
    logic             w_all_match;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pcie_chk_lane #(
            .LANE_IDX (g),
            .MAX_LAT  (MAX_LAT),
            .LAT_W    (LAT_W)
        ) u_lane (
            .clk         (PCLK250),
            .rst_n       (CNTL_RESETN_P0),
            .i_cnt       (r_cnt),
            .i_lat       (r_lat),
            .i_rx_data   (rx_data[8*g +: 8]),
            .i_rx_datak  (rx_datak[g]),
            .o_gen_data  (gen_data[8*g +: 8]),
            .o_gen_datak (gen_datak[g]),
            .o_match_c   (w_match[g])
        );
    end

    // Generator counter and TX-enable history; txen follows the lane-0 byte.
    always_ff @(posedge PCLK250 or negedge CNTL_RESETN_P0) begin
        if (!CNTL_RESETN_P0) begin
            r_cnt <= '0;
            for (int unsigned k = 0; k <= MAX_LAT; k++) begin
                r_txen_hist[k] <= 1'b0;
            end
        end else begin
            if (gen_en) begin
                r_cnt <= r_cnt + 8'd1;
            end
            r_txen_hist[0] <= (r_cnt != idle_code);
            for (int unsigned k = 1; k <= MAX_LAT; k++) begin
                r_txen_hist[k] <= r_txen_hist[k-1];
            end
        end
    end

    assign w_cmp        = rx_valid && r_txen_hist[r_lat];
    assign w_all_match  = &w_match;
    assign w_run_inc    = r_run + RUN_W'(1);
    assign w_consec_inc = r_consec + CON_W'(1);

    // Checker state register.
    always_ff @(posedge PCLK250 or negedge CNTL_RESETN_P0) begin
        if (!CNTL_RESETN_P0) begin
            r_state    <= SEARCH;
            r_lat      <= '0;
            r_run      <= '0;
            r_consec   <= '0;
            r_err_cnt  <= '0;
            r_lane_err <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lat      <= w_lat_nxt;
            r_run      <= w_run_nxt;
            r_consec   <= w_consec_nxt;
            r_err_cnt  <= w_err_nxt;
            r_lane_err <= w_lane_err_nxt;
        end
    end

    // Latency search / lock tracking; clr_err is applied before this cycle's event.
    always_comb begin
        w_state_nxt    = r_state;
        w_lat_nxt      = r_lat;
        w_run_nxt      = r_run;
        w_consec_nxt   = r_consec;
        w_err_nxt      = clr_err ? '0 : r_err_cnt;
        w_lane_err_nxt = clr_err ? '0 : r_lane_err;
        if (w_cmp) begin
            case (r_state)
                SEARCH: begin
                    if (w_all_match) begin
                        if (w_run_inc == RUN_W'(LOCK_CNT)) begin
                            w_state_nxt = LOCKED;
                            w_run_nxt   = '0;
                        end else begin
                            w_run_nxt = w_run_inc;
                        end
                    end else begin
                        w_run_nxt = '0;
                        w_lat_nxt = (r_lat == LAT_W'(MAX_LAT)) ? '0 : r_lat + LAT_W'(1);
                    end
                end
                LOCKED: begin
                    if (w_all_match) begin
                        w_consec_nxt = '0;
                    end else begin
                        if (w_err_nxt != {CNT_W{1'b1}}) begin
                            w_err_nxt = w_err_nxt + CNT_W'(1);
                        end
                        w_lane_err_nxt = w_lane_err_nxt | ~w_match;
                        if (w_consec_inc == CON_W'(ERR_LIMIT)) begin
                            w_state_nxt  = SEARCH;
                            w_lat_nxt    = '0;
                            w_run_nxt    = '0;
                            w_consec_nxt = '0;
                        end else begin
                            w_consec_nxt = w_consec_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign gen_txen = r_txen_hist[0];
    assign locked   = (r_state == LOCKED);
    assign lat      = r_lat;
    assign err_cnt  = r_err_cnt;
    assign lane_err = r_lane_err;

endmodule

// File: tb/tb_pcie_loopback_checker.sv
// Bench for pcie_loopback_checker: randomized loopback traffic against a cycle-log reference model.
module tb_pcie_loopback_checker;

    localparam int unsigned LANES     = 4;
    localparam int unsigned MAX_LAT   = 8;
    localparam int unsigned LOCK_CNT  = 16;
    localparam int unsigned ERR_LIMIT = 4;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned LAT_W     = $clog2(MAX_LAT + 1);
    localparam int unsigned SV_W      = 1 + LAT_W + CNT_W + LANES;
    localparam int unsigned DW        = 8 * LANES;

    typedef struct packed {
        logic [DW-1:0]    d;
        logic [LANES-1:0] k;
        logic             t;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             gen_en = 1'b0;
    logic [7:0]       idle_code = 8'h25;
    logic             clr_err = 1'b0;
    logic             rx_valid = 1'b0;
    logic [DW-1:0]    rx_data = '0;
    logic [LANES-1:0] rx_datak = '0;
    logic [DW-1:0]    gen_data;
    logic [LANES-1:0] gen_datak;
    logic             gen_txen;
    logic             locked;
    logic [LAT_W-1:0] lat;
    logic [CNT_W-1:0] err_cnt;
    logic [LANES-1:0] lane_err;

    always #5 clk = ~clk;

    pcie_loopback_checker #(
        .LANES(LANES), .MAX_LAT(MAX_LAT), .LOCK_CNT(LOCK_CNT),
        .ERR_LIMIT(ERR_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .PCLK250(clk), .CNTL_RESETN_P0(rst_n), .gen_en(gen_en), .idle_code(idle_code),
        .clr_err(clr_err), .gen_data(gen_data), .gen_datak(gen_datak), .gen_txen(gen_txen),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_datak(rx_datak), .locked(locked),
        .lat(lat), .err_cnt(err_cnt), .lane_err(lane_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: log of every generator output since reset (entry 0 = reset value).
    beat_t            log_q[$];
    int               m_cnt, m_lat, m_run, m_consec, m_err;
    bit               m_locked;
    logic [LANES-1:0] m_lerr;
    int               g_delay;

    function automatic bit kset(input logic [7:0] b);
        logic [7:0] codes [11] = '{8'h1C, 8'h3C, 8'h5C, 8'h9C, 8'hBC, 8'hDC,
                                   8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        foreach (codes[i]) if (codes[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic beat_t gen_beat(input int c);
        beat_t      b;
        logic [7:0] by;
        for (int i = 0; i < int'(LANES); i++) begin
            by            = 8'((c + i) % 256);
            b.d[8*i +: 8] = by;
            b.k[i]        = kset(by);
        end
        b.t = (8'(c) != 8'h25);
        return b;
    endfunction

    // Generator output from k cycles before the current one.
    function automatic beat_t hist_at(input int k);
        int idx;
        idx = log_q.size() - 1 - k;
        if (idx < 0) return '0;
        return log_q[idx];
    endfunction

    function automatic bit next_cmp();
        beat_t h;
        h = hist_at(m_lat);
        return rx_valid && h.t;
    endfunction

    function automatic logic [SV_W-1:0] m_vec();
        return {m_locked, LAT_W'(m_lat), CNT_W'(m_err), m_lerr};
    endfunction

    function automatic logic [SV_W-1:0] d_vec();
        return {locked, lat, err_cnt, lane_err};
    endfunction

    task automatic model_reset();
        log_q.delete();
        log_q.push_back('0);
        m_cnt = 0; m_lat = 0; m_run = 0; m_consec = 0; m_err = 0;
        m_locked = 1'b0; m_lerr = '0;
    endtask

    // Applies one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        beat_t            h;
        logic [LANES-1:0] mism;
        h = hist_at(m_lat);
        if (clr_err) begin m_err = 0; m_lerr = '0; end
        if (rx_valid && h.t) begin
            mism = '0;
            for (int i = 0; i < int'(LANES); i++)
                if (rx_data[8*i +: 8] !== h.d[8*i +: 8] || rx_datak[i] !== h.k[i]) mism[i] = 1'b1;
            if (!m_locked) begin
                if (mism == '0) begin
                    m_run++;
                    if (m_run == int'(LOCK_CNT)) begin m_locked = 1'b1; m_run = 0; end
                end else begin
                    m_run = 0;
                    m_lat = (m_lat == int'(MAX_LAT)) ? 0 : m_lat + 1;
                end
            end else if (mism == '0) begin
                m_consec = 0;
            end else begin
                if (m_err < (1 << CNT_W) - 1) m_err++;
                m_lerr = m_lerr | mism;
                m_consec++;
                if (m_consec == int'(ERR_LIMIT)) begin
                    m_locked = 1'b0; m_lat = 0; m_run = 0; m_consec = 0;
                end
            end
        end
        log_q.push_back(gen_beat(m_cnt));
        if (gen_en) m_cnt = (m_cnt + 1) % 256;
    endtask

    // Drive the looped-back beat (optionally corrupted), clock once, land on the falling edge.
    task automatic cycle(input logic [DW-1:0] flip);
        beat_t b;
        b        = hist_at(g_delay);
        rx_data  = b.d ^ flip;
        rx_datak = b.k;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({d_vec(), gen_data, gen_datak, gen_txen} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got %0h expected 0", {d_vec(), gen_data, gen_datak, gen_txen});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        gen_en = 1'b1; rx_valid = 1'b0; g_delay = 2;
        cycle('0);
        n_tests++;
        if ({gen_data, gen_datak, gen_txen} !== {32'h03020100, 4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL first_beat: got %0h expected %0h", {gen_data, gen_datak, gen_txen},
                     {32'h03020100, 4'b0000, 1'b1});
        end
    endtask

    task automatic test_gen_random();
        logic [DW-1:0] flip;
        g_delay = 3;
        for (int i = 0; i < 400; i++) begin
            gen_en   = ($urandom_range(3) != 0);
            rx_valid = ($urandom_range(4) != 0);
            clr_err  = ($urandom_range(30) == 0);
            flip     = ($urandom_range(12) == 0) ? (DW'(1) << $urandom_range(DW - 1)) : '0;
            cycle(flip);
            n_tests++;
            if ({gen_data, gen_datak, gen_txen} !== log_q[$]) begin
                n_fail++;
                $display("FAIL rand_gen: got %0h expected %0h", {gen_data, gen_datak, gen_txen}, log_q[$]);
            end
            n_tests++;
            if (d_vec() !== m_vec()) begin
                n_fail++;
                $display("FAIL rand_state: got %0h expected %0h", d_vec(), m_vec());
            end
        end
        clr_err = 1'b0;
    endtask

    task automatic test_lock();
        int ncmp = 0;
        int lock_at = -1;
        do_reset();
        g_delay = 2; gen_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rx_valid = ($urandom_range(7) != 0);
            if (next_cmp()) ncmp++;
            cycle('0);
            if (locked === 1'b1 && lock_at < 0) lock_at = ncmp;
            n_tests++;
            if (d_vec() !== m_vec()) begin
                n_fail++;
                $display("FAIL lock_state: got %0h expected %0h", d_vec(), m_vec());
            end
        end
        n_tests++;
        if (lock_at < 0 || lock_at > 3 * int'(LOCK_CNT)) begin
            n_fail++;
            $display("FAIL lock_time: got %0d compares required <= %0d", lock_at, 3 * LOCK_CNT);
        end
        n_tests++;
        if ({locked, lat, err_cnt} !== {1'b1, LAT_W'(2), CNT_W'(0)}) begin
            n_fail++;
            $display("FAIL lock_final: got locked=%0b lat=%0d err=%0d expected 1/2/0", locked, lat, err_cnt);
        end
    endtask

    task automatic test_kcodes();
        logic [7:0] b0;
        beat_t      h;
        rx_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            h = hist_at(m_lat);
            cycle(h.t ? '0 : '1);
            b0 = gen_data[7:0];
            if (b0 == 8'h1C || b0 == 8'h7C || b0 == 8'hF7 || b0 == 8'h25) begin
                n_tests++;
                if ({gen_datak[0], gen_txen} !== {(b0 == 8'h1C || b0 == 8'hF7), (b0 != 8'h25)}) begin
                    n_fail++;
                    $display("FAIL kcode_%0h: got k=%0b txen=%0b", b0, gen_datak[0], gen_txen);
                end
            end
            n_tests++;
            if ({gen_data, gen_datak, gen_txen} !== log_q[$]) begin
                n_fail++;
                $display("FAIL kcode_gen: got %0h expected %0h", {gen_data, gen_datak, gen_txen}, log_q[$]);
            end
        end
        n_tests++;
        if ({locked, err_cnt, lane_err} !== {1'b1, CNT_W'(0), 4'b0000}) begin
            n_fail++;
            $display("FAIL gap_not_compared: got locked=%0b err=%0d lane_err=%0b expected 1/0/0",
                     locked, err_cnt, lane_err);
        end
    endtask

    task automatic test_single_err();
        bit done = 1'b0;
        rx_valid = 1'b1;
        clr_err = 1'b1; cycle('0); clr_err = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (next_cmp()) begin cycle(32'h0000_0100); done = 1'b1; end
            else cycle('0);
        end
        n_tests++;
        if (!done || {locked, err_cnt, lane_err} !== {1'b1, CNT_W'(1), 4'b0010}) begin
            n_fail++;
            $display("FAIL single_err: got locked=%0b err=%0d lane_err=%0b expected 1/1/0010",
                     locked, err_cnt, lane_err);
        end
        for (int i = 0; i < 5; i++) begin
            cycle('0);
            n_tests++;
            if (d_vec() !== m_vec()) begin
                n_fail++;
                $display("FAIL single_err_after: got %0h expected %0h", d_vec(), m_vec());
            end
        end
    endtask

    task automatic test_drop_lock();
        int  nbad = 0;
        int  ncmp = 0;
        bit  done = 1'b0;
        rx_valid = 1'b1;
        clr_err = 1'b1; cycle('0); clr_err = 1'b0;
        for (int i = 0; i < 20 && nbad < 4; i++) begin
            if (next_cmp()) begin
                cycle(32'h0000_0008);
                nbad++;
                n_tests++;
                if (locked !== (nbad < 4)) begin
                    n_fail++;
                    $display("FAIL drop_locked_%0d: got %0b expected %0b", nbad, locked, (nbad < 4));
                end
            end else cycle('0);
        end
        n_tests++;
        if ({locked, lat, err_cnt, lane_err} !== {1'b0, LAT_W'(0), CNT_W'(4), 4'b0001}) begin
            n_fail++;
            $display("FAIL drop_state: got locked=%0b lat=%0d err=%0d lane_err=%0b expected 0/0/4/0001",
                     locked, lat, err_cnt, lane_err);
        end
        for (int i = 0; i < 400 && locked !== 1'b1; i++) begin
            if (next_cmp()) ncmp++;
            cycle('0);
            n_tests++;
            if (d_vec() !== m_vec()) begin
                n_fail++;
                $display("FAIL relock_state: got %0h expected %0h", d_vec(), m_vec());
            end
        end
        n_tests++;
        if (locked !== 1'b1 || lat !== LAT_W'(2) || ncmp != 2 + int'(LOCK_CNT)) begin
            n_fail++;
            $display("FAIL relock: got locked=%0b lat=%0d compares=%0d expected 1/2/%0d",
                     locked, lat, ncmp, 2 + LOCK_CNT);
        end
        for (int i = 0; i < 10 && !done; i++) begin
            if (next_cmp()) begin
                clr_err = 1'b1; cycle(32'h0001_0000); clr_err = 1'b0; done = 1'b1;
            end else cycle('0);
        end
        n_tests++;
        if (!done || {locked, err_cnt, lane_err} !== {1'b1, CNT_W'(1), 4'b0100}) begin
            n_fail++;
            $display("FAIL clr_with_err: got locked=%0b err=%0d lane_err=%0b expected 1/1/0100",
                     locked, err_cnt, lane_err);
        end
    endtask

    task automatic test_no_lock();
        bit               saw_wrap = 1'b0;
        logic [LAT_W-1:0] prev;
        do_reset();
        g_delay = 9; gen_en = 1'b1; rx_valid = 1'b1;
        prev = lat;
        for (int i = 0; i < 700; i++) begin
            cycle('0);
            if (prev == LAT_W'(MAX_LAT) && lat == '0) saw_wrap = 1'b1;
            prev = lat;
            n_tests++;
            if (locked !== 1'b0 || d_vec() !== m_vec()) begin
                n_fail++;
                $display("FAIL nolock_state: got %0h expected %0h", d_vec(), m_vec());
            end
        end
        n_tests++;
        if (!saw_wrap) begin
            n_fail++;
            $display("FAIL lat_wrap: got no 8->0 transition, required at least one");
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        g_delay = 2; gen_en = 1'b1; rx_valid = 1'b1;
        for (int i = 0; i < 100 && locked !== 1'b1; i++) cycle('0);
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_lock: got locked=%0b expected 1", locked);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({d_vec(), gen_data, gen_datak, gen_txen} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %0h expected 0", {d_vec(), gen_data, gen_datak, gen_txen});
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_gen_random();
        test_lock();
        test_kcodes();
        test_single_err();
        test_drop_lock();
        test_no_lock();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
